// File: rtl/atctlc2axi500_arb_pkg.sv
// Shared definitions for the TLC-to-AXI round-robin arbiter.
// Holds the arbiter state encoding used by atctlc2axi500_rr_arb.
package atctlc2axi500_arb_pkg;

  // IDLE: arbitrating freely each cycle; LOCK: grant pinned to a burst owner.
  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

endpackage

// File: rtl/atctlc2axi500_mux_onehot.sv
// One-hot selected payload multiplexer.
// Ports:
//   sel  - one-hot select, N bits (all-zero gives a zero result)
//   din  - packed inputs, input i at [i*W+:W]
//   dout - selected payload, W bits
module atctlc2axi500_mux_onehot #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic [N-1:0]   sel,
  input  logic [N*W-1:0] din,
  output logic [W-1:0]   dout
);

  // AND-OR mux: a zero select naturally yields zero, no priority chain.
  always_comb begin
    dout = '0;
    for (int i = 0; i < N; i++) begin
      if (sel[i]) begin
        dout = dout | din[i*W +: W];
      end
    end
  end

endmodule

// File: rtl/atctlc2axi500_rr_arb.sv
// Round-robin arbiter sharing one AXI-side channel between N requesters.
// The grant is combinational in IDLE and pinned to the burst owner in LOCK
// until that owner's last beat is accepted.
// Ports:
//   aclk, aresetn       - clock, asynchronous active-low reset
//   req_valid/req_last  - per-requester valid and last-beat flag (N bits)
//   req_data            - packed payloads, requester i at [i*W+:W]
//   req_ready           - per-requester ready (only the granted one may be high)
//   out_valid/out_last  - downstream valid and last-beat flag
//   out_data            - selected payload
//   out_ready           - downstream ready
//   out_grant           - current one-hot grant, zero when nothing granted
//   busy                - high while locked on a burst
module atctlc2axi500_rr_arb
  import atctlc2axi500_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic           aclk,
  input  logic           aresetn,
  input  logic [N-1:0]   req_valid,
  input  logic [N-1:0]   req_last,
  input  logic [N*W-1:0] req_data,
  output logic [N-1:0]   req_ready,
  output logic           out_valid,
  output logic           out_last,
  output logic [W-1:0]   out_data,
  input  logic           out_ready,
  output logic [N-1:0]   out_grant,
  output logic           busy
);

  arb_state_t   state, state_nxt;
  logic [N-1:0] ptr, ptr_nxt;
  logic [N-1:0] lock_grant, lock_grant_nxt;
  logic [N-1:0] rr_grant;
  logic         handshake;

  // Search upward from the pointer with wrap: scan a doubled request vector
  // starting at the pointer position, then fold the two halves back together.
  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] req,
                                           input logic [N-1:0] pri);
    logic [2*N-1:0] dbl;
    logic [2*N-1:0] hit;
    logic           found;
    int             base;
    dbl   = {req, req};
    hit   = '0;
    found = 1'b0;
    base  = 0;
    for (int i = 0; i < N; i++) begin
      if (pri[i]) base = i;
    end
    for (int k = 0; k < 2*N; k++) begin
      if (!found && (k >= base) && dbl[k]) begin
        hit[k] = 1'b1;
        found  = 1'b1;
      end
    end
    return hit[2*N-1:N] | hit[N-1:0];
  endfunction

  function automatic logic [N-1:0] rotl1(input logic [N-1:0] v);
    return {v[N-2:0], v[N-1]};
  endfunction

  assign rr_grant  = rr_pick(req_valid, ptr);
  assign out_grant = (state == LOCK) ? lock_grant : rr_grant;
  assign out_valid = |(req_valid & out_grant);
  assign req_ready = out_ready ? out_grant : '0;
  assign handshake = out_valid & out_ready;
  assign busy      = (state == LOCK);

  atctlc2axi500_mux_onehot #(.N(N), .W(W)) u_data_mux (
    .sel  (out_grant),
    .din  (req_data),
    .dout (out_data)
  );

  atctlc2axi500_mux_onehot #(.N(N), .W(1)) u_last_mux (
    .sel  (out_grant),
    .din  (req_last),
    .dout (out_last)
  );

  // A non-last beat opens a lock on the current winner; the last beat of a
  // transfer hands top priority to the requester after the winner.
  always_comb begin
    state_nxt      = state;
    ptr_nxt        = ptr;
    lock_grant_nxt = lock_grant;
    case (state)
      IDLE: begin
        if (handshake) begin
          if (out_last) begin
            ptr_nxt = rotl1(out_grant);
          end else begin
            state_nxt      = LOCK;
            lock_grant_nxt = out_grant;
          end
        end
      end
      LOCK: begin
        if (handshake && out_last) begin
          state_nxt      = IDLE;
          ptr_nxt        = rotl1(lock_grant);
          lock_grant_nxt = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= IDLE;
      ptr        <= {{(N-1){1'b0}}, 1'b1};
      lock_grant <= '0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      lock_grant <= lock_grant_nxt;
    end
  end

endmodule

// File: tb/tb_atctlc2axi500_rr_arb.sv
// Self-checking bench for atctlc2axi500_rr_arb (N=4, W=8).
// A behavioural model tracks the priority index and burst owner as integers
// and predicts every output each cycle; directed scenarios add literal checks.
module tb_atctlc2axi500_rr_arb;
  localparam int N = 4;
  localparam int W = 8;

  logic           aclk = 1'b0;
  logic           aresetn = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_last = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic           out_last;
  logic [W-1:0]   out_data;
  logic           out_ready = 1'b0;
  logic [N-1:0]   out_grant;
  logic           busy;

  int checks = 0;
  int errors = 0;

  // Model state: index of the highest-priority requester, burst lock flag
  // and the owning requester index.
  int m_prio  = 0;
  bit m_lock  = 1'b0;
  int m_owner = 0;

  // Free-running clock, 10 time units per cycle.
  always #5 aclk = ~aclk;

  atctlc2axi500_rr_arb #(.N(N), .W(W)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .req_valid (req_valid),
    .req_last  (req_last),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_data  (out_data),
    .out_ready (out_ready),
    .out_grant (out_grant),
    .busy      (busy)
  );

  // Winner index under the model: the owner while locked, otherwise the
  // first valid requester counting up from m_prio with wrap; -1 if none.
  function automatic int model_winner(input logic [N-1:0] v);
    int w;
    w = -1;
    if (m_lock) begin
      w = m_owner;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (w < 0 && v[(m_prio + k) % N]) w = (m_prio + k) % N;
      end
    end
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle's worth of inputs just after the next rising edge.
  task automatic applyStimulus(input logic [N-1:0] v, input logic [N-1:0] l,
                               input logic [N*W-1:0] d, input logic r);
    @(posedge aclk);
    #1;
    req_valid = v;
    req_last  = l;
    req_data  = d;
    out_ready = r;
  endtask

  task automatic pulseReset();
    @(posedge aclk);
    #1;
    aresetn   = 1'b0;
    req_valid = '0;
    out_ready = 1'b0;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  // Advance the model on each edge from the inputs seen during the cycle;
  // reset forces priority back to requester 0 and clears any lock.
  always @(posedge aclk or negedge aresetn) begin
    int w;
    if (!aresetn) begin
      m_prio  <= 0;
      m_lock  <= 1'b0;
      m_owner <= 0;
    end else begin
      w = model_winner(req_valid);
      if (w >= 0 && req_valid[w] && out_ready) begin
        if (req_last[w]) begin
          m_lock <= 1'b0;
          m_prio <= (w + 1) % N;
        end else begin
          m_lock  <= 1'b1;
          m_owner <= w;
        end
      end
    end
  end

  // Compare every DUT output against the model on each falling edge.
  always @(negedge aclk) begin
    int w;
    logic [N-1:0] g;
    w = model_winner(req_valid);
    g = (w >= 0) ? (N'(1) << w) : '0;
    checkOutput("grant", 32'(out_grant), 32'(g));
    checkOutput("valid", 32'(out_valid), (w >= 0) ? 32'(req_valid[w]) : 32'd0);
    checkOutput("last", 32'(out_last), (w >= 0) ? 32'(req_last[w]) : 32'd0);
    checkOutput("data", 32'(out_data), (w >= 0) ? 32'(req_data[w*W +: W]) : 32'd0);
    checkOutput("ready", 32'(req_ready), out_ready ? 32'(g) : 32'd0);
    checkOutput("busy", 32'(busy), 32'(m_lock));
  end

  // Directed scenarios with hand-computed expectations, then random traffic.
  initial begin
    logic [N*W-1:0] d0;
    d0 = {8'h33, 8'h22, 8'h11, 8'h00};

    $display("[TB] reset state");
    repeat (2) @(posedge aclk);
    #2;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_grant", 32'(out_grant), 32'd0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;

    $display("[TB] alternating requesters 1 and 3");
    applyStimulus(4'b1010, 4'b1111, d0, 1'b1);
    @(negedge aclk);
    checkOutput("s1_g0", 32'(out_grant), 32'h2);
    checkOutput("s1_d0", 32'(out_data), 32'h11);
    applyStimulus(4'b1010, 4'b1111, d0, 1'b1);
    @(negedge aclk);
    checkOutput("s1_g1", 32'(out_grant), 32'h8);
    checkOutput("s1_d1", 32'(out_data), 32'h33);
    applyStimulus(4'b1010, 4'b1111, d0, 1'b1);
    @(negedge aclk);
    checkOutput("s1_g2", 32'(out_grant), 32'h2);

    $display("[TB] all four single-beat");
    pulseReset();
    for (int k = 0; k < 8; k++) begin
      applyStimulus(4'b1111, 4'b1111, d0, 1'b1);
      @(negedge aclk);
      checkOutput("s2_order", 32'(out_grant), 32'(1 << (k % 4)));
    end

    $display("[TB] 3-beat burst on requester 2");
    pulseReset();
    applyStimulus(4'b0010, 4'b1111, d0, 1'b1);
    applyStimulus(4'b0101, 4'b0001, d0, 1'b1);
    @(negedge aclk);
    checkOutput("s3_b1_grant", 32'(out_grant), 32'h4);
    checkOutput("s3_b1_busy", 32'(busy), 32'd0);
    applyStimulus(4'b0101, 4'b0001, d0, 1'b1);
    @(negedge aclk);
    checkOutput("s3_b2_busy", 32'(busy), 32'd1);
    checkOutput("s3_b2_ready", 32'(req_ready), 32'h4);
    applyStimulus(4'b0101, 4'b0101, d0, 1'b1);
    @(negedge aclk);
    checkOutput("s3_b3_busy", 32'(busy), 32'd1);
    checkOutput("s3_b3_ready", 32'(req_ready), 32'h4);
    applyStimulus(4'b0001, 4'b0001, d0, 1'b1);
    @(negedge aclk);
    checkOutput("s3_next_grant", 32'(out_grant), 32'h1);
    checkOutput("s3_next_busy", 32'(busy), 32'd0);

    $display("[TB] stalled burst with valid drop");
    applyStimulus(4'b0100, 4'b0000, d0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      applyStimulus((k == 1 || k == 2) ? 4'b0001 : 4'b0101, 4'b0001, d0, 1'b0);
      @(negedge aclk);
      checkOutput("s4_hold_grant", 32'(out_grant), 32'h4);
      checkOutput("s4_hold_busy", 32'(busy), 32'd1);
    end
    applyStimulus(4'b0101, 4'b0101, d0, 1'b1);
    @(negedge aclk);
    checkOutput("s4_resume_valid", 32'(out_valid), 32'd1);
    checkOutput("s4_resume_last", 32'(out_last), 32'd1);
    applyStimulus(4'b1111, 4'b1111, d0, 1'b1);
    @(negedge aclk);
    checkOutput("s4_after_grant", 32'(out_grant), 32'h8);

    $display("[TB] reset during lock on requester 3");
    applyStimulus(4'b1000, 4'b0000, d0, 1'b1);
    applyStimulus(4'b1000, 4'b0000, d0, 1'b0);
    @(negedge aclk);
    checkOutput("s5_locked", 32'(busy), 32'd1);
    #2;
    aresetn = 1'b0;
    #1;
    checkOutput("s5_busy_async", 32'(busy), 32'd0);
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    applyStimulus(4'b1111, 4'b1111, d0, 1'b1);
    @(negedge aclk);
    checkOutput("s5_first_grant", 32'(out_grant), 32'h1);

    $display("[TB] no requests");
    for (int k = 0; k < 3; k++) begin
      applyStimulus(4'b0000, 4'b1111, d0, 1'b1);
      @(negedge aclk);
      checkOutput("s6_valid", 32'(out_valid), 32'd0);
      checkOutput("s6_grant", 32'(out_grant), 32'd0);
      checkOutput("s6_data", 32'(out_data), 32'd0);
      checkOutput("s6_ready", 32'(req_ready), 32'd0);
      checkOutput("s6_busy", 32'(busy), 32'd0);
    end

    $display("[TB] random traffic");
    for (int k = 0; k < 1500; k++) begin
      applyStimulus(4'($urandom), 4'($urandom), {$urandom}, ($urandom_range(0, 3) != 0));
    end

    @(negedge aclk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/atctlc2axi500_rr_arb.md
# atctlc2axi500_rr_arb

Round-robin arbiter that shares one AXI-side channel between N requesters inside the TLC-to-AXI bridge. It computes a one-hot grant over valid/ready requesters and keeps that grant locked for the full length of a multi-beat transfer. It drives the select of a one-hot payload multiplexer and presents a single valid/ready/last stream downstream.

## Interface

- N, 4, number of requesters (≥2)
- W, 8, payload width per requester
- aclk  input  1  clock; all state updates on rising edge
- aresetn  input  1  asynchronous active-low reset
- req_valid  input  N  per-requester valid
- req_last  input  N  per-requester last-beat flag
- req_data  input  N*W  packed payloads; requester i at [i*W+:W]
- req_ready  output  N  per-requester ready
- out_valid  output  1  downstream valid
- out_last  output  1  downstream last-beat flag
- out_data  output  W  muxed payload
- out_ready  input  1  downstream ready
- out_grant  output  N  current one-hot grant, zero when no grant
- busy  output  1  high while the arbiter is in LOCK

## Operation

- Registered state: `state` (IDLE/LOCK), `ptr` (one-hot priority pointer, N bits), `lock_grant` (one-hot, N bits).
- IDLE:
  - `out_grant` is the first set bit of `req_valid`, searching upward from `ptr` with wrap from N-1 to 0.
  - If no `req_valid` bit is set, `out_grant` = 0.
- LOCK: `out_grant` = `lock_grant`, independent of the other requesters.
- Downstream stream:
  - `out_valid` = |(`req_valid` & `out_grant`).
  - `out_last` = |(`req_last` & `out_grant`).
  - `out_data` = one-hot mux of `req_data` by `out_grant`; 0 when the grant is zero.
- `req_ready[i]` = `out_grant[i]` & `out_ready`. Non-granted requesters always see ready low.
- Handshake means `out_valid` & `out_ready`.
- Transitions:
  - IDLE, handshake, `out_last`=1: stay IDLE; `ptr` <= `out_grant` rotated left by 1, so the requester after the winner gets highest priority.
  - IDLE, handshake, `out_last`=0: go to LOCK; `lock_grant` <= `out_grant`; `ptr` unchanged.
  - LOCK, handshake, `out_last`=1: go to IDLE; `ptr` <= `lock_grant` rotated left by 1; `lock_grant` <= 0.
  - LOCK, no handshake, or handshake without last: hold.
  - IDLE, no handshake: hold. Grant may change cycle to cycle while downstream stalls.
- Requester protocol: once `req_valid[i]` is asserted, payload and last stay stable until `req_ready[i]`. The arbiter does not check this.
- A locked requester that drops valid mid-burst gives `out_valid`=0. The lock is held until its last beat.
- `busy` = (`state` == LOCK).

## Timing

- Reset values: `state`=IDLE, `ptr`=1 (requester 0 highest), `lock_grant`=0.
- Outputs right after reset:
  - `busy`=0.
  - `out_valid`, `out_last`, `out_grant`, `out_data` and `req_ready` are combinational and are 0 when `req_valid`=0.
- The request-to-grant path is combinational, with zero-cycle latency. A single-beat transfer completes in the cycle it is presented if `out_ready`=1.
- `ptr`, `state` and `lock_grant` change on the edge following the handshake. The new priority applies from the next cycle.
- Back-to-back single-beat transfers from different requesters are sustained at 1 per cycle.
- Simultaneous last-beat handshake and new requests: the new requests are arbitrated next cycle using the updated `ptr`.
- Reset mid-burst: the arbiter returns to IDLE immediately with `ptr`=1. The burst is abandoned, and recovery is the requesters' responsibility.

## Structure

- Package `atctlc2axi500_arb_pkg`: state encoding constants (IDLE=1'b0, LOCK=1'b1).
- Sub-module `atctlc2axi500_mux_onehot` (N, W) for `out_data`. Also reuse it with W=1 for `out_last` if convenient.
- Rotating priority search is a local function or a generate loop over a doubled request vector (2N bits); no extra sub-module.

## Test plan

Parameters for all scenarios: N=4, W=8.

1. After reset, `req_valid`=4'b1010 with data 0x11 (requester 1) and 0x33 (requester 3), `req_last`=all 1, `out_ready`=1 -> cycle 0 grants requester 1 (`out_data`=0x11), cycle 1 grants requester 3 (0x33), cycle 2 grants requester 1 again.
2. All four requesters valid with single-beat transfers, `out_ready`=1 for 8 cycles -> grant order 0,1,2,3,0,1,2,3.
3. Requester 2 runs a 3-beat burst (last on beat 3) while requester 0 is also valid -> `busy`=1 for beats 2–3; `req_ready[0]`=0 throughout; requester 0 is granted the cycle after beat 3.
4. `out_ready`=0 for 5 cycles during a locked burst, and requester 2 drops valid for 2 cycles -> `out_grant` stays 4'b0100; no `ptr` or `state` change; the burst resumes correctly.
5. `aresetn` is asserted while LOCK on requester 3 -> `busy`=0 immediately; after release with all requesters valid, requester 0 is granted first.
6. `req_valid`=0 -> `out_valid`=0, `out_grant`=0, `out_data`=0, `req_ready`=0, and the state holds.
